// File: rtl/perf_counter_bank_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : perf_pkg                                                      |
// | Brief    : Shared defaults, slot constant and step-FSM state encoding    |
// |            for the performance-counter / display-select bank.            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package perf_pkg;

  localparam int DEF_NUM_CH    = 3;
  localparam int DEF_CNT_BITS  = 32;
  localparam int DEF_DISP_BITS = 32;
  localparam int DEF_HOLDOFF   = 4;

  // Slot 0 always carries the program's syscall output, live.
  localparam int SLOT_EXT = 0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } step_state_e;

endpackage
`default_nettype wire

// File: rtl/perf_counter_bank_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface: perf_counter_bank_if                                          |
// | Brief    : Control, event and display signals of the counter bank.       |
// |            master = core/board side, slave = perf_counter_bank.          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface perf_counter_bank_if
  import perf_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int DISP_BITS = DEF_DISP_BITS
);
  localparam int SEL_BITS = $clog2(NUM_CH + 1);

  logic                 run;
  logic [NUM_CH-1:0]    events;
  logic                 clear;
  logic                 freeze;
  logic                 step;
  logic [DISP_BITS-1:0] ext_data;
  logic [DISP_BITS-1:0] disp_data;
  logic [SEL_BITS-1:0]  disp_sel;
  logic [NUM_CH-1:0]    overflow;

  modport master (
    output run, events, clear, freeze, step, ext_data,
    input  disp_data, disp_sel, overflow
  );

  modport slave (
    input  run, events, clear, freeze, step, ext_data,
    output disp_data, disp_sel, overflow
  );

endinterface
`default_nettype wire

// File: rtl/perf_counter_bank_btn_edge_holdoff.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : btn_edge_holdoff                                              |
// | Brief    : Rising-edge detector for the raw step button with a holdoff   |
// |            window; emits a single-cycle advance pulse per accepted press.|
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module btn_edge_holdoff
  import perf_pkg::*;
#(
  parameter int HOLDOFF = DEF_HOLDOFF
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic step,
  output logic      advance
);

  localparam int            HW        = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF - 1);

  step_state_e   state_q, state_d;
  logic          step_q;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          rise;

  // Next-state logic; advance is decoded combinationally so the selector
  // moves on the same edge that samples the button rising edge.
  always_comb begin
    rise       = step && !step_q;
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    advance    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          advance    = 1'b1;
          hold_cnt_d = HOLD_LOAD;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Button history, FSM state and holdoff counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      step_q     <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step;
      hold_cnt_q <= hold_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/perf_counter_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : perf_counter_bank                                             |
// | Brief    : NUM_CH gated event counters with sticky overflow, freeze      |
// |            snapshot and a step-button display selector feeding the       |
// |            seven-segment driver.                                         |
// | Config   : PERF_CNT_SATURATE_EN defined -> counters saturate at all-ones;|
// |            undefined -> counters wrap to zero.                           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int CNT_BITS  = DEF_CNT_BITS,
  parameter int DISP_BITS = DEF_DISP_BITS,
  parameter int HOLDOFF   = DEF_HOLDOFF
) (
  input wire logic             clk,
  input wire logic             rst,
  perf_counter_bank_if.slave   bus
);

  localparam int SEL_BITS = $clog2(NUM_CH + 1);

  logic [DISP_BITS-1:0] live_val [NUM_CH];
  logic [DISP_BITS-1:0] snap_val [NUM_CH];
  logic [NUM_CH-1:0]    ovf_vec;
  logic                 freeze_q;
  logic                 snap;
  logic [SEL_BITS-1:0]  disp_sel_q, disp_sel_d;
  logic                 advance;
  logic [DISP_BITS-1:0] disp_mux;

  // Snapshot is taken on the cycle freeze first goes high.
  assign snap = bus.freeze && !freeze_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [CNT_BITS-1:0] shadow_q, shadow_d;
    logic                ovf_q, ovf_d;

    // Count, overflow and snapshot update; clear beats increment and never
    // touches the shadow, which captures the pre-update count.
    always_comb begin
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      shadow_d = shadow_q;
      if (bus.clear) begin
        cnt_d = '0;
        ovf_d = 1'b0;
      end else if (bus.run && bus.events[i]) begin
        if (&cnt_q) begin
          ovf_d = 1'b1;
`ifdef PERF_CNT_SATURATE_EN
          cnt_d = cnt_q;
`else
          cnt_d = '0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_BITS'(1);
        end
      end
      if (snap) begin
        shadow_d = cnt_q;
      end
    end

    // Per-channel state registers.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q    <= '0;
        shadow_q <= '0;
        ovf_q    <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        shadow_q <= shadow_d;
        ovf_q    <= ovf_d;
      end
    end

    // Size casts zero-extend narrow counters and keep the low bits of wide ones.
    assign live_val[i] = DISP_BITS'(cnt_q);
    assign snap_val[i] = DISP_BITS'(shadow_q);
    assign ovf_vec[i]  = ovf_q;
  end

  btn_edge_holdoff #(
    .HOLDOFF (HOLDOFF)
  ) u_step (
    .clk     (clk),
    .rst     (rst),
    .step    (bus.step),
    .advance (advance)
  );

  // Selector walks 0..NUM_CH and wraps back to the external-data slot.
  always_comb begin
    disp_sel_d = disp_sel_q;
    if (advance) begin
      disp_sel_d = (disp_sel_q == SEL_BITS'(NUM_CH)) ? SEL_BITS'(SLOT_EXT)
                                                     : disp_sel_q + SEL_BITS'(1);
    end
  end

  // Freeze edge history and selector registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      freeze_q   <= 1'b0;
      disp_sel_q <= SEL_BITS'(SLOT_EXT);
    end else begin
      freeze_q   <= bus.freeze;
      disp_sel_q <= disp_sel_d;
    end
  end

  // Unregistered display mux; slot 0 stays live even while frozen.
  always_comb begin
    disp_mux = bus.ext_data;
    for (int k = 0; k < NUM_CH; k++) begin
      if (disp_sel_q == SEL_BITS'(k + 1)) begin
        disp_mux = bus.freeze ? snap_val[k] : live_val[k];
      end
    end
  end

  assign bus.disp_data = disp_mux;
  assign bus.disp_sel  = disp_sel_q;
  assign bus.overflow  = ovf_vec;

endmodule
`default_nettype wire
